// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NREQ requesters.
// Define MULT_SHARE_SCHED_STATS_EN to add the grant_cnt statistics output.
module mult_share_sched #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*10-1:0]        req_a,
  input  logic [NREQ*10-1:0]        req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [9:0]                mul_a,
  output logic [9:0]                mul_b,
  output logic                      mul_ce,
  output logic                      mul_reset,
  input  logic [19:0]               mul_dout,
  output logic                      res_valid,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [19:0]               res_dout,
  output logic                      busy
`ifdef MULT_SHARE_SCHED_STATS_EN
  ,
  output logic [15:0]               grant_cnt
`endif
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [1:0]         rst_q;
  logic               rst_n;
  state_t             state;
  logic [IW-1:0]      last;
  logic [MUL_LAT-1:0] vp;
  logic [MUL_LAT-1:0] vp_nxt;
  logic [IW-1:0]      idp [MUL_LAT];
  logic [IW-1:0]      gidx;
  logic [IW:0]        j;
  logic               gnt;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_q <= '0;
    else          rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n = rst_q[1];

  always_comb begin
    gnt  = 1'b0;
    gidx = '0;
    j    = '0;
    // Walk offsets from far to near so the nearest valid one wins.
    for (int o = NREQ; o >= 1; o--) begin
      j = {1'b0, last} + (IW+1)'(o);
      if (j >= (IW+1)'(NREQ)) j = j - (IW+1)'(NREQ);
      if (req_valid[j[IW-1:0]]) begin
        gnt  = 1'b1;
        gidx = j[IW-1:0];
      end
    end
    if (!(state == RUN && enable)) gnt = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (gnt) begin
      req_ready[gidx] = 1'b1;
      mul_a           = req_a[10*gidx +: 10];
      mul_b           = req_b[10*gidx +: 10];
    end
  end

  assign vp_nxt    = (vp << 1) | MUL_LAT'(gnt);
  assign mul_ce    = (state != IDLE);
  assign mul_reset = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = vp[MUL_LAT-1];
  assign res_id    = idp[MUL_LAT-1];
  assign res_dout  = res_valid ? mul_dout : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= IW'(NREQ-1);
      vp    <= '0;
      for (int i = 0; i < MUL_LAT; i++) idp[i] <= '0;
    end else begin
      if (mul_ce) begin
        vp     <= vp_nxt;
        idp[0] <= gnt ? gidx : '0;
        for (int i = 1; i < MUL_LAT; i++) idp[i] <= idp[i-1];
      end
      if (gnt) last <= gidx;
      unique case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= (|vp_nxt) ? DRAIN : IDLE;
        DRAIN: begin
          if (enable)        state <= RUN;
          else if (!(|vp_nxt)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_SHARE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   grant_cnt <= '0;
    else if (gnt) grant_cnt <= grant_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mult_share_sched.sv
// Randomized bench for mult_share_sched with a queue-based result model
// and a behavioural multiplier standing in for the shared DSP.
module tb_mult_share_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IW   = $clog2(NREQ);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*10-1:0]   req_a;
  logic [NREQ*10-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [9:0]           mul_a;
  logic [9:0]           mul_b;
  logic                 mul_ce;
  logic                 mul_reset;
  logic [19:0]          mul_dout;
  logic                 res_valid;
  logic [IW-1:0]        res_id;
  logic [19:0]          res_dout;
  logic                 busy;
`ifdef MULT_SHARE_SCHED_STATS_EN
  logic [15:0]          grant_cnt;
`endif

  always #5 clk = ~clk;

  mult_share_sched #(.NREQ(NREQ), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ce(mul_ce), .mul_reset(mul_reset), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_id(res_id), .res_dout(res_dout),
    .busy(busy)
`ifdef MULT_SHARE_SCHED_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  // Shared multiplier: LAT-stage pipe, CE-gated, sync reset.
  logic signed [19:0] mp [LAT];
  always_ff @(posedge clk) begin
    if (mul_reset) begin
      for (int i = 0; i < LAT; i++) mp[i] <= '0;
    end else if (mul_ce) begin
      mp[0] <= $signed(mul_a) * $signed(mul_b);
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_dout = mp[LAT-1];

  logic signed [9:0] a [NREQ];
  logic signed [9:0] b [NREQ];
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_a[10*i +: 10] = a[i];
      req_b[10*i +: 10] = b[i];
    end
  end

  typedef struct {
    int         due;
    int         id;
    logic [19:0] p;
  } res_t;

  res_t            q[$];
  int              m_state;
  int              m_last;
  int              m_gcnt;
  int              cyc_n;
  int              total;
  int              bad;
  logic [NREQ-1:0] pend;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(output int w);
    logic [NREQ-1:0]    er;
    logic [9:0]         ea;
    logic [9:0]         eb;
    logic signed [19:0] p;
    logic               ev;
    int                 jj;
    res_t               r;
    @(negedge clk);
    w = -1;
    if (m_state == 1 && enable && reset_n)
      for (int o = 1; o <= NREQ; o++) begin
        jj = (m_last + o) % NREQ;
        if (req_valid[jj] && w < 0) w = jj;
      end
    er = '0;
    ea = '0;
    eb = '0;
    if (w >= 0) begin
      er[w] = 1'b1;
      ea = a[w];
      eb = b[w];
    end
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("mul_a", 32'(mul_a), 32'(ea));
    chk("mul_b", 32'(mul_b), 32'(eb));
    if (w >= 0) begin
      p = a[w] * b[w];
      r.due = cyc_n + LAT;
      r.id  = w;
      r.p   = p;
      q.push_back(r);
      m_last = w;
      m_gcnt++;
    end
    ev = (q.size() > 0) && (q[0].due == cyc_n);
    chk("res_valid", 32'(res_valid), 32'(ev));
    if (ev) begin
      chk("res_id", 32'(res_id), 32'(q[0].id));
      chk("res_dout", 32'(res_dout), 32'(q[0].p));
      void'(q.pop_front());
    end else begin
      chk("res_dout_idle", 32'(res_dout), 32'd0);
    end
    if (!reset_n) chk("res_id_rst", 32'(res_id), 32'd0);
    chk("busy", 32'(busy), 32'(m_state != 0));
    chk("mul_ce", 32'(mul_ce), 32'(m_state != 0));
    chk("mul_reset", 32'(mul_reset), 32'(m_state == 0));
    if (!reset_n) m_state = 0;
    else
      case (m_state)
        0: if (enable) m_state = 1;
        1: if (!enable) m_state = (q.size() > 0) ? 2 : 0;
        default: begin
          if (enable) m_state = 1;
          else if (q.size() == 0) m_state = 0;
        end
      endcase
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  // Requesters hold operands and valid until granted; prob refills idle ones.
  task automatic run(input int n, input int prob);
    int w;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(99) < prob) begin
          pend[i] = 1'b1;
          a[i] = 10'($urandom_range(1023));
          b[i] = 10'($urandom_range(1023));
        end
      req_valid = pend;
      cyc(w);
      if (w >= 0) pend[w] = 1'b0;
    end
  endtask

  task automatic rst(input int n);
    int w;
    reset_n   = 1'b0;
    enable    = 1'b0;
    pend      = '0;
    req_valid = '0;
    q.delete();
    m_state = 0;
    m_last  = NREQ - 1;
    m_gcnt  = 0;
    for (int k = 0; k < n; k++) cyc(w);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(w);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc_n = 0;
    reset_n = 1'b0;
    enable  = 1'b0;
    pend    = '0;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    @(posedge clk);
    #1;
    rst(2);

    // single request 3 * -5
    enable = 1'b1;
    pend = 4'b0001;
    a[0] = 10'sd3;
    b[0] = -10'sd5;
    run(5, 0);

    // continuous contention: strict rotation, back-to-back results
    run(8, 100);
    pend = '0;

    // extreme operands
    pend = 4'b0110;
    a[1] = -10'sd512;
    b[1] = -10'sd512;
    a[2] = 10'sd511;
    b[2] = -10'sd512;
    run(4, 0);

    // drain: two grants, then enable drops
    pend = 4'b0011;
    run(2, 0);
    enable = 1'b0;
    pend = '0;
    run(4, 0);

    // random traffic with enable toggling
    enable = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(15) == 0) enable = ~enable;
      run(1, 40);
    end
    enable = 1'b0;
    run(4, 0);

    // reset one cycle after a grant discards it; rotation restarts at 0
    enable = 1'b1;
    run(2, 100);
    rst(1);
    enable = 1'b1;
    run(10, 100);
    enable = 1'b0;
    run(4, 0);

`ifdef MULT_SHARE_SCHED_STATS_EN
    rst(1);
    enable = 1'b1;
    for (int g = 0; m_gcnt < 70000 && g < 80000; g++) run(1, 100);
    chk("grant_cnt", 32'(grant_cnt), 32'd4464);
    enable = 1'b0;
    run(4, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
MULT_SHARE_SCHED -- requirements
Module: mult_share_sched

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters (2..8); MUL_LAT, default 2, multiplier latency in cycles with CE high.
REQ-002 Port clk SHALL be: input, 1 bit, single clock for all logic.
REQ-003 Port reset_n SHALL be: input, 1 bit, asynchronous, active-low reset.
REQ-004 Port enable SHALL be: input, 1 bit, permits new grants.
REQ-005 Port req_valid SHALL be: input, NREQ bits, one request strobe per requester.
REQ-006 Port req_a SHALL be: input, NREQ*10 bits, signed operand A, requester i in bits [10i+9:10i].
REQ-007 Port req_b SHALL be: input, NREQ*10 bits, signed operand B, packed the same way as req_a.
REQ-008 Port req_ready SHALL be: output, NREQ bits, one-hot grant.
REQ-009 Port mul_a SHALL be: output, 10 bits, operand A to the shared multiplier.
REQ-010 Port mul_b SHALL be: output, 10 bits, operand B to the shared multiplier.
REQ-011 Port mul_ce SHALL be: output, 1 bit, multiplier clock enable.
REQ-012 Port mul_reset SHALL be: output, 1 bit, active-high synchronous reset for the multiplier.
REQ-013 Port mul_dout SHALL be: input, 20 bits, signed product from the multiplier.
REQ-014 Port res_valid SHALL be: output, 1 bit, result strobe.
REQ-015 Port res_id SHALL be: output, clog2(NREQ) bits, index of the requester that owns the result.
REQ-016 Port res_dout SHALL be: output, 20 bits, signed product.
REQ-017 Port busy SHALL be: output, 1 bit, high whenever state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, DRAIN.
REQ-019 The FSM SHALL transition IDLE->RUN when enable=1.
REQ-020 The FSM SHALL transition RUN->DRAIN when enable=0 and at least one product is in flight, and RUN->IDLE when enable=0 and nothing is in flight.
REQ-021 The FSM SHALL transition DRAIN->IDLE when the in-flight count is 0, and DRAIN->RUN when enable=1 (enable takes priority over the drain).
REQ-022 Grants SHALL be issued only in RUN: at most one bit of req_ready is high per cycle, and only for a requester whose req_valid is high.
REQ-023 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod NREQ, and last_grant resets to NREQ-1, so requester 0 wins first.
REQ-024 req_ready SHALL be combinational from req_valid, state and last_grant; a transfer occurs when req_valid[i] and req_ready[i] are both high, and the requester holds its operands until that transfer.
REQ-025 mul_a and mul_b SHALL carry the granted requester's operands in the grant cycle, and 0 in any cycle with no grant.
REQ-026 mul_ce SHALL be 1 in RUN and DRAIN and 0 in IDLE.
REQ-027 mul_reset SHALL be 1 in IDLE and 0 otherwise.
REQ-028 A valid/id shift pipe of depth MUL_LAT SHALL advance every cycle while mul_ce=1.
REQ-029 A grant in cycle k SHALL produce res_valid=1 in cycle k+MUL_LAT, with res_id equal to the granted index.
REQ-030 res_dout SHALL equal mul_dout when res_valid=1 and 0 otherwise; there is no result back-pressure.
REQ-031 Throughput SHALL be one grant per cycle; with back-to-back grants to different requesters, results appear back-to-back in grant order.
REQ-032 The in-flight count SHALL equal the number of 1s in the valid pipe; a grant and a retire in the same cycle leave the count unchanged.
REQ-033 When enable falls in cycle k, no grant SHALL occur in cycle k, and all earlier grants SHALL still produce results.

Reset
REQ-034 While reset_n=0, the block SHALL hold: state IDLE, valid pipe cleared, last_grant=NREQ-1, req_ready=0, res_valid=0, res_dout=0, res_id=0, mul_ce=0, mul_reset=1, busy=0.
REQ-035 Reset assertion SHALL discard all in-flight results, and no res_valid SHALL appear after release until new grants are made.
REQ-036 Reset release SHALL be synchronized to clk with a 2-flop synchronizer that keeps asynchronous assertion.

Configuration
REQ-037 With MULT_SHARE_SCHED_STATS_EN defined, the block SHALL add output grant_cnt, 16 bits, that counts grants, wraps at 0xFFFF->0, and is cleared by reset.
REQ-038 With MULT_SHARE_SCHED_STATS_EN undefined, grant_cnt and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Single request: enable=1; req_valid=0001, a0=3, b0=-5 -> req_ready=0001 in cycle k; res_valid in cycle k+2 with res_id=0, res_dout=-15.
REQ-040 Fair rotation: all four requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3, and 8 consecutive results with matching ids.
REQ-041 Extreme operands: a=-512, b=-512 -> res_dout=262144; a=511, b=-512 -> res_dout=-261632.
REQ-042 Drain: grants in cycles 5 and 6, enable=0 in cycle 7 -> no grant in cycle 7, results in cycles 7 and 8, IDLE in cycle 9, busy=0.
REQ-043 Mid-flight reset: reset_n low for 1 cycle, 1 cycle after a grant -> no res_valid afterwards, next grant goes to requester 0.
REQ-044 With STATS_EN defined: 70000 grants -> grant_cnt=4464.
